// File: rtl/systolic_feeder.sv
// Operand buffers plus triangular skew sequencer feeding an N x N systolic array.
// Define FEEDER_ZERO_BUBBLE_EN to force data lanes to zero whenever their valid is low.
module systolic_feeder #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int AW = 7
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic                              wr_sel,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] wr_lane,
    input  logic [AW-1:0]                     wr_addr,
    input  logic [DW-1:0]                     wr_data,
    input  logic                              start,
    input  logic [AW:0]                       len,
    output logic                              busy,
    output logic                              done,
    output logic                              pe_clr,
    output logic [N*DW-1:0]                   a_out,
    output logic [N*DW-1:0]                   b_out,
    output logic [N-1:0]                      a_vld,
    output logic [N-1:0]                      b_vld
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = ((AW + 1) > ($clog2(N + 1) + 1)) ? (AW + 1) : ($clog2(N + 1) + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [CW-1:0]  cnt;
    logic [AW:0]    len_q;
    logic [AW:0]    len_clamped;
    logic [AW-1:0]  rd_addr;
    logic           wr_ok;
    logic [N:0]     vchain;

    assign len_clamped = len[AW] ? {1'b1, {AW{1'b0}}} : len;
    assign rd_addr     = cnt[AW-1:0];
    assign wr_ok       = wr_en && (state == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start && (len != '0)) next_state = S_CLEAR;
            S_CLEAR:  next_state = S_STREAM;
            S_STREAM: if ((cnt + 1'b1) == CW'(len_q)) next_state = S_DRAIN;
            S_DRAIN:  if (cnt == CW'(N)) next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        pe_clr = 1'b0;
        busy   = (state != S_IDLE);
        done   = (state == S_DONE);
        pe_clr = (state == S_CLEAR);
    end

    // cnt doubles as read address in STREAM and drain timer in DRAIN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            len_q <= '0;
        end else begin
            if (state == S_IDLE && start && (len != '0)) begin
                len_q <= len_clamped;
            end
            if (next_state != state) begin
                cnt <= '0;
            end else if (state == S_STREAM || state == S_DRAIN) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // vchain[0] tags the RAM output register; vchain[i+1] is lane i's output valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vchain <= '0;
        end else begin
            vchain <= {vchain[N-1:0], state == S_STREAM};
        end
    end

    assign a_vld = vchain[N:1];
    assign b_vld = vchain[N:1];

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] a_mem [2**AW];
        logic [DW-1:0] b_mem [2**AW];
        logic [DW-1:0] a_sh  [i+2];
        logic [DW-1:0] b_sh  [i+2];

        always_ff @(posedge clk) begin
            if (wr_ok && wr_lane == LW'(i)) begin
                if (wr_sel) begin
                    b_mem[wr_addr] <= wr_data;
                end else begin
                    a_mem[wr_addr] <= wr_data;
                end
            end
        end

        // Stage 0 is the RAM read register; stages 1..i+1 form the skew delay
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j <= i + 1; j++) begin
                    a_sh[j] <= '0;
                    b_sh[j] <= '0;
                end
            end else begin
                a_sh[0] <= a_mem[rd_addr];
                b_sh[0] <= b_mem[rd_addr];
                for (int j = 1; j <= i + 1; j++) begin
                    if (vchain[j-1]) begin
                        a_sh[j] <= a_sh[j-1];
                        b_sh[j] <= b_sh[j-1];
                    end
`ifdef FEEDER_ZERO_BUBBLE_EN
                    else begin
                        a_sh[j] <= '0;
                        b_sh[j] <= '0;
                    end
`endif
                end
            end
        end

        assign a_out[i*DW +: DW] = a_sh[i+1];
        assign b_out[i*DW +: DW] = b_sh[i+1];
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Parametrised operand buffer and skew sequencer for an N×N systolic multiply array. Holds N lanes of A-operand (row) and N lanes of B-operand (column) vectors in on-chip buffers. On `start`, streams `len` vectors per lane into the array with triangular skew: lane i is delayed i+1 cycles relative to issue. It also generates accumulator-clear, per-lane valid, busy and done, replacing fixed 4-lane hand-wired delay chains.

## Interface
- `N`, 4, lane count (array dimension), ≥1
- `DW`, 16, operand width
- `AW`, 7, buffer address width; depth per lane = 2^AW
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous reset, active-low
- `wr_en`  in  1  buffer write strobe
- `wr_sel`  in  1  0 = A buffer, 1 = B buffer
- `wr_lane`  in  $clog2(N) (min 1)  target lane
- `wr_addr`  in  AW  target word
- `wr_data`  in  DW  write data
- `start`  in  1  begin a stream (sampled in IDLE only)
- `len`  in  AW+1  vectors to stream, sampled with `start`
- `busy`  out  1  high from the cycle after accepted `start` through DONE
- `done`  out  1  one-cycle pulse at end of drain
- `pe_clr`  out  1  one-cycle pulse, clears PE accumulators
- `a_out`  out  N*DW  lane i at [i*DW +: DW]
- `b_out`  out  N*DW  lane i at [i*DW +: DW]
- `a_vld`, `b_vld`  out  N  per-lane valid (identical vectors)

## Operation
- Buffers: 2×N single-write, synchronous-read memories, DW × 2^AW each. Contents are not reset.
- Writes are accepted only when `busy`=0. `wr_en` while busy is dropped.
- Accepted `start`: IDLE, `start`=1, `len`≠0. Start with `len`=0 is ignored. `len` > 2^AW clamps to 2^AW. `start` while busy is ignored.
- FSM states:
  - IDLE: accepted start → CLEAR.
  - CLEAR: 1 cycle, `pe_clr`=1 → STREAM.
  - STREAM: `len` cycles; read address k = 0..len-1 on all 2N buffers → DRAIN.
  - DRAIN: N+1 cycles → DONE.
  - DONE: 1 cycle, `done`=1 → IDLE.
- Skew: the read word from buffer lane i passes through i+1 registers after the RAM output register. Lanes are 0-indexed.
- The valid pipeline runs parallel to the data pipeline. `a_vld[i]`/`b_vld[i]` are high exactly when lane i carries element k of the current stream.
- Outside valid, data lanes are forced to 0 (see Configuration).
- No arithmetic; data passes unmodified.

## Timing
- T0 = first STREAM cycle; CLEAR occupies T0-1.
- Element k of lane i appears on `a_out`/`b_out` lane i during cycle T0+k+i+2.
- Last element: lane N-1, cycle T0+len+N, which is the last DRAIN cycle.
- `done` is high in cycle T0+len+N+1. `busy` falls in the following cycle.
- A new `start` is accepted no earlier than the cycle after DONE.
- Reset values: `busy`, `done`, `pe_clr`, `a_out`, `b_out`, `a_vld`, `b_vld` all 0; FSM in IDLE.
- Reset asserted mid-operation: all pipeline and valid registers clear immediately and the FSM returns to IDLE. No `done` is produced; buffer contents are retained.

## Configuration
- `FEEDER_ZERO_BUBBLE_EN` defined: data lanes are 0 whenever the lane's valid is low.
- Not defined: a lane's data registers load only when upstream valid is high. Outside the valid window each lane holds its last element, saving the output muxes.
- Valid, timing and FSM behaviour are identical in both builds.

## Test plan
- Reset: drive `rst`=0 mid-clock → all outputs 0 at once and `busy`=0. Release, idle 5 cycles → outputs stay 0.
- Stream: N=4, load A[i][k]=16'h0i0k and B[i][k]=16'h1i0k, start with `len`=3. Required response:
  - `pe_clr` at T0-1.
  - `a_out` lane 2 = 16'h0201 at T0+5.
  - `b_out` lane 3 = 16'h1302 at T0+7.
  - `a_vld`=4'b0001 at T0+2.
  - `done` at T0+8; `busy` low at T0+9.
- Collisions: assert `start` and `wr_en` (A, lane 0, addr 0, 16'hFFFF) mid-STREAM. Required: no restart, and a second stream still reads the original 16'h0000.
- Bounds: `len`=0 → stays IDLE, `busy`=0. With AW=7, `len`=200 → clamps to 128, `done` at T0+133.
- Abort: reset during STREAM cycle 2, then restart with `len`=2 → correct data, `done` at T0'+7.
- Macro off: after the `len`=3 run, lane 1 holds 16'h0102 and lane 0 holds 16'h0002 with valid low. Macro on: both lanes 0.
